// File: rtl/npu_sdram_arbiter.sv
`timescale 1ns/1ps
// npu_sdram_arbiter
// Two Avalon-MM requesters share the HPS f2h_sdram0 slave. Grants are
// round-robin on ties, write bursts hold the grant until their last beat,
// and a small tag FIFO routes returning read beats back to the requester
// whose read was accepted first.
module npu_sdram_arbiter #(
   parameter int ADDR_W    = 28,
   parameter int DATA_W    = 128,
   parameter int BE_W      = 16,
   parameter int BURST_W   = 8,
   parameter int RDQ_DEPTH = 4
) (
   input  logic               sys_clk_clk,
   input  logic               sys_rst_reset_n,
   input  logic [ADDR_W-1:0]  m0_address,
   input  logic [BURST_W-1:0] m0_burstcount,
   input  logic               m0_read,
   input  logic               m0_write,
   input  logic [DATA_W-1:0]  m0_writedata,
   input  logic [BE_W-1:0]    m0_byteenable,
   output logic               m0_waitrequest,
   output logic [DATA_W-1:0]  m0_readdata,
   output logic               m0_readdatavalid,
   input  logic [ADDR_W-1:0]  m1_address,
   input  logic [BURST_W-1:0] m1_burstcount,
   input  logic               m1_read,
   input  logic               m1_write,
   input  logic [DATA_W-1:0]  m1_writedata,
   input  logic [BE_W-1:0]    m1_byteenable,
   output logic               m1_waitrequest,
   output logic [DATA_W-1:0]  m1_readdata,
   output logic               m1_readdatavalid,
   output logic [ADDR_W-1:0]  s_address,
   output logic [BURST_W-1:0] s_burstcount,
   output logic               s_read,
   output logic               s_write,
   output logic [DATA_W-1:0]  s_writedata,
   output logic [BE_W-1:0]    s_byteenable,
   input  logic               s_waitrequest,
   input  logic [DATA_W-1:0]  s_readdata,
   input  logic               s_readdatavalid,
   output logic               err_rdv
);

   localparam int PTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(RDQ_DEPTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WBURST = 2'd2} state_t;

   state_t             state;
   logic               gnt;
   logic               lst;
   logic [BURST_W-1:0] wb_cnt;

   logic               tag_port  [RDQ_DEPTH];
   logic [BURST_W-1:0] tag_beats [RDQ_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   fill;

   logic               req0, req1;
   logic               g_read, g_write, g_wait;
   logic [BURST_W-1:0] g_burstcount, g_beats;
   logic               in_cmd, in_wb;
   logic               fifo_full, fifo_empty;
   logic               rd_accept, wr_accept;
   logic               head_valid, push, pop;

   // Command mux, waitrequest steering and read-return routing.
   always_comb begin
      req0         = m0_read | m0_write;
      req1         = m1_read | m1_write;
      g_read       = gnt ? m1_read : m0_read;
      g_write      = gnt ? m1_write : m0_write;
      g_burstcount = gnt ? m1_burstcount : m0_burstcount;
      g_beats      = (g_burstcount == '0) ? BURST_W'(1) : g_burstcount;
      fifo_full    = (fill == CNT_W'(RDQ_DEPTH));
      fifo_empty   = (fill == '0);
      in_cmd       = sys_rst_reset_n & (state == CMD);
      in_wb        = sys_rst_reset_n & (state == WBURST);

      s_address    = gnt ? m1_address : m0_address;
      s_burstcount = g_burstcount;
      s_writedata  = gnt ? m1_writedata : m0_writedata;
      s_byteenable = gnt ? m1_byteenable : m0_byteenable;
      s_read       = in_cmd & g_read & ~fifo_full;
      s_write      = (in_cmd | in_wb) & g_write;

      g_wait = 1'b1;
      if (in_cmd) begin
         g_wait = s_waitrequest | (g_read & fifo_full);
      end else if (in_wb) begin
         g_wait = s_waitrequest | ~g_write;
      end
      m0_waitrequest = gnt ? 1'b1 : g_wait;
      m1_waitrequest = gnt ? g_wait : 1'b1;

      rd_accept  = s_read & ~s_waitrequest;
      wr_accept  = s_write & ~s_waitrequest;
      push       = rd_accept;
      head_valid = sys_rst_reset_n & s_readdatavalid & ~fifo_empty;
      pop        = head_valid & (tag_beats[rd_ptr] == BURST_W'(1));

      m0_readdata      = s_readdata;
      m1_readdata      = s_readdata;
      m0_readdatavalid = head_valid & ~tag_port[rd_ptr];
      m1_readdatavalid = head_valid & tag_port[rd_ptr];
   end

   // Arbitration FSM: grant on request, hold through write bursts, update last-served.
   always_ff @(posedge sys_clk_clk) begin
      if (!sys_rst_reset_n) begin
         state  <= IDLE;
         gnt    <= 1'b0;
         lst    <= 1'b1;
         wb_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 & req1) begin
                  gnt   <= ~lst;
                  state <= CMD;
               end else if (req0) begin
                  gnt   <= 1'b0;
                  state <= CMD;
               end else if (req1) begin
                  gnt   <= 1'b1;
                  state <= CMD;
               end
            end
            CMD: begin
               if (rd_accept) begin
                  lst   <= gnt;
                  state <= IDLE;
               end else if (wr_accept) begin
                  if (g_beats == BURST_W'(1)) begin
                     lst   <= gnt;
                     state <= IDLE;
                  end else begin
                     wb_cnt <= g_beats - BURST_W'(1);
                     state  <= WBURST;
                  end
               end else if (!g_read && !g_write) begin
                  state <= IDLE;
               end
            end
            WBURST: begin
               if (wr_accept) begin
                  wb_cnt <= wb_cnt - BURST_W'(1);
                  if (wb_cnt == BURST_W'(1)) begin
                     lst   <= gnt;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag FIFO: one entry per accepted read, head entry counts down its beats.
   always_ff @(posedge sys_clk_clk) begin
      if (!sys_rst_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) begin
            tag_port[wr_ptr]  <= gnt;
            tag_beats[wr_ptr] <= g_beats;
            wr_ptr <= (wr_ptr == PTR_W'(RDQ_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (head_valid) begin
            if (pop) begin
               rd_ptr <= (rd_ptr == PTR_W'(RDQ_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end else begin
               tag_beats[rd_ptr] <= tag_beats[rd_ptr] - BURST_W'(1);
            end
         end
         if (push && !pop) begin
            fill <= fill + CNT_W'(1);
         end else if (pop && !push) begin
            fill <= fill - CNT_W'(1);
         end
      end
   end

   // Sticky error on a read beat that no outstanding read can own.
   always_ff @(posedge sys_clk_clk) begin
      if (!sys_rst_reset_n) begin
         err_rdv <= 1'b0;
      end else if (s_readdatavalid && fifo_empty) begin
         err_rdv <= 1'b1;
      end
   end

endmodule

// File: tb/tb_npu_sdram_arbiter.sv
`timescale 1ns/1ps
// tb_npu_sdram_arbiter
// Directed scenarios against a queue-based behavioural model that is
// checked on every falling edge, plus literal checks of each scenario.
module tb_npu_sdram_arbiter;

   typedef struct {
      bit port;
      int beats;
   } tag_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [27:0]  maddr  [2];
   logic [7:0]   mbc    [2];
   logic [1:0]   mrd, mwr;
   logic [127:0] mwdata [2];
   logic [15:0]  mbe    [2];
   logic [1:0]   mwait, mrdv;
   logic [127:0] mrdata [2];
   logic [27:0]  s_address;
   logic [7:0]   s_burstcount;
   logic         s_read, s_write;
   logic [127:0] s_writedata;
   logic [15:0]  s_byteenable;
   logic         s_wait, s_rdv;
   logic [127:0] s_rdata;
   logic         err_rdv;

   int n_checks = 0;
   int n_fail   = 0;

   int   m_phase;
   bit   m_gnt, m_last, m_err;
   int   m_left;
   tag_t m_q[$];

   logic [27:0] wr_log[$];
   bit          rdv_log[$];
   int          cnt_sread = 0;
   int          cnt_rdv0  = 0;
   int          cnt_rdv1  = 0;

   npu_sdram_arbiter dut (
      .sys_clk_clk      (clk),
      .sys_rst_reset_n  (rst_n),
      .m0_address       (maddr[0]),
      .m0_burstcount    (mbc[0]),
      .m0_read          (mrd[0]),
      .m0_write         (mwr[0]),
      .m0_writedata     (mwdata[0]),
      .m0_byteenable    (mbe[0]),
      .m0_waitrequest   (mwait[0]),
      .m0_readdata      (mrdata[0]),
      .m0_readdatavalid (mrdv[0]),
      .m1_address       (maddr[1]),
      .m1_burstcount    (mbc[1]),
      .m1_read          (mrd[1]),
      .m1_write         (mwr[1]),
      .m1_writedata     (mwdata[1]),
      .m1_byteenable    (mbe[1]),
      .m1_waitrequest   (mwait[1]),
      .m1_readdata      (mrdata[1]),
      .m1_readdatavalid (mrdv[1]),
      .s_address        (s_address),
      .s_burstcount     (s_burstcount),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_wait),
      .s_readdata       (s_rdata),
      .s_readdatavalid  (s_rdv),
      .err_rdv          (err_rdv)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) next_cycle();
   endtask

   task automatic apply_stimulus(input int p, input bit rd, input bit wr, input logic [27:0] a,
                                 input logic [7:0] bc, input logic [127:0] d);
      mrd[p]    = rd;
      mwr[p]    = wr;
      maddr[p]  = a;
      mbc[p]    = bc;
      mwdata[p] = d;
      mbe[p]    = 16'hFFFF;
   endtask

   // Holds the current command until the port sees waitrequest low; drops it after acceptance.
   task automatic wait_accept(input int p, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         #3;
         if (mwait[p] == 1'b0) ok = 1'b1;
         next_cycle();
      end
      if (ok) begin
         mrd[p] = 1'b0;
         mwr[p] = 1'b0;
      end
   endtask

   // Reference model: compare outputs mid-cycle, then advance to the next edge.
   initial begin : compare_proc
      int   p;
      int   b;
      bit   full, rd_acc, wr_acc, act;
      logic e_sread, e_swrite;
      logic [1:0] e_wait, e_rdv;
      tag_t h;
      @(posedge clk);
      forever begin
         @(negedge clk);
         p    = int'(m_gnt);
         full = (m_q.size() >= 4);
         act  = rst_n && (m_phase != 0);
         e_sread  = rst_n && (m_phase == 1) && mrd[p] && !full;
         e_swrite = act && mwr[p];
         e_wait   = 2'b11;
         if (rst_n && m_phase == 1) e_wait[p] = (mrd[p] && full) ? 1'b1 : s_wait;
         if (rst_n && m_phase == 2) e_wait[p] = s_wait;
         e_rdv = 2'b00;
         if (rst_n && s_rdv && m_q.size() > 0) e_rdv[m_q[0].port] = 1'b1;

         check_output("s_read", s_read, e_sread);
         check_output("s_write", s_write, e_swrite);
         check_output("waitrequest", mwait, e_wait);
         check_output("readdatavalid", mrdv, e_rdv);
         check_output("err_rdv", err_rdv, m_err);
         check_output("m0_readdata", mrdata[0], s_rdata);
         check_output("m1_readdata", mrdata[1], s_rdata);
         if (act) begin
            check_output("s_address", s_address, maddr[p]);
            check_output("s_burstcount", s_burstcount, mbc[p]);
            check_output("s_writedata", s_writedata, mwdata[p]);
            check_output("s_byteenable", s_byteenable, mbe[p]);
         end

         if (s_read) cnt_sread++;
         if (s_write && !s_wait) wr_log.push_back(s_address);
         if (mrdv[0]) begin cnt_rdv0++; rdv_log.push_back(1'b0); end
         if (mrdv[1]) begin cnt_rdv1++; rdv_log.push_back(1'b1); end

         if (!rst_n) begin
            m_phase = 0;
            m_gnt   = 1'b0;
            m_last  = 1'b1;
            m_left  = 0;
            m_err   = 1'b0;
            m_q.delete();
         end else begin
            rd_acc = (m_phase == 1) && mrd[p] && !full && !s_wait;
            wr_acc = (m_phase != 0) && mwr[p] && !s_wait;
            b      = (mbc[p] == 8'd0) ? 1 : int'(mbc[p]);
            if (s_rdv) begin
               if (m_q.size() == 0) begin
                  m_err = 1'b1;
               end else begin
                  h = m_q[0];
                  h.beats--;
                  if (h.beats == 0) void'(m_q.pop_front());
                  else m_q[0] = h;
               end
            end
            case (m_phase)
               0: begin
                  if ((mrd[0] | mwr[0]) && (mrd[1] | mwr[1])) begin
                     m_gnt = !m_last; m_phase = 1;
                  end else if (mrd[0] | mwr[0]) begin
                     m_gnt = 1'b0; m_phase = 1;
                  end else if (mrd[1] | mwr[1]) begin
                     m_gnt = 1'b1; m_phase = 1;
                  end
               end
               1: begin
                  if (rd_acc) begin
                     m_q.push_back('{port: m_gnt, beats: b});
                     m_last = m_gnt; m_phase = 0;
                  end else if (wr_acc) begin
                     if (b <= 1) begin
                        m_last = m_gnt; m_phase = 0;
                     end else begin
                        m_left = b - 1; m_phase = 2;
                     end
                  end else if (!mrd[p] && !mwr[p]) begin
                     m_phase = 0;
                  end
               end
               default: begin
                  if (wr_acc) begin
                     m_left--;
                     if (m_left == 0) begin
                        m_last = m_gnt; m_phase = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Hard time limit so the bench always ends.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] time limit reached");
   end

   // Directed scenarios.
   initial begin : stimulus
      bit ok, m0_hold, same;
      int mark, mark2, beats, r0, r1, s0;
      bit exp_route [10];
      exp_route = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0; s_wait = 1'b0; s_rdv = 1'b0; s_rdata = '0;
      apply_stimulus(0, 0, 0, '0, 8'd1, '0);
      apply_stimulus(1, 0, 0, '0, 8'd1, '0);
      tick(2);
      #3;
      check_output("reset_s_read", s_read, 1'b0);
      check_output("reset_s_write", s_write, 1'b0);
      check_output("reset_wait", mwait, 2'b11);
      check_output("reset_rdv", mrdv, 2'b00);
      check_output("reset_err", err_rdv, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      $display("[TB] single read, burstcount 0, stray readdatavalid");
      s0 = cnt_sread; r0 = cnt_rdv0; r1 = cnt_rdv1;
      apply_stimulus(0, 1, 0, 28'h100, 8'd4, '0);
      #3;
      check_output("lat_idle_s_read", s_read, 1'b0);
      next_cycle();
      #3;
      check_output("lat_cmd_s_read", s_read, 1'b1);
      check_output("lat_cmd_wait0", mwait[0], 1'b0);
      next_cycle();
      mrd[0] = 1'b0;
      #3;
      check_output("after_acc_s_read", s_read, 1'b0);
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         s_rdv = 1'b1; s_rdata = 128'hA0 + 128'(i);
         next_cycle();
      end
      s_rdv = 1'b0;
      check_output("single_rdv0_count", 128'(cnt_rdv0 - r0), 128'd4);
      check_output("single_rdv1_count", 128'(cnt_rdv1 - r1), 128'd0);
      check_output("single_s_read_cycles", 128'(cnt_sread - s0), 128'd1);
      r1 = cnt_rdv1;
      apply_stimulus(1, 1, 0, 28'h200, 8'd0, '0);
      wait_accept(1, 5, ok);
      check_output("bc0_read_accept", ok, 1'b1);
      s_rdv = 1'b1; s_rdata = 128'hB0;
      next_cycle();
      s_rdv = 1'b0;
      check_output("bc0_rdv1_count", 128'(cnt_rdv1 - r1), 128'd1);
      check_output("bc0_err_clear", err_rdv, 1'b0);
      s_rdv = 1'b1; s_rdata = 128'hEE;
      #3;
      check_output("stray_no_rdv", mrdv, 2'b00);
      next_cycle();
      s_rdv = 1'b0;
      #3;
      check_output("stray_err_set", err_rdv, 1'b1);
      next_cycle();
      tick(4);
      #3;
      check_output("stray_err_sticky", err_rdv, 1'b1);
      next_cycle();

      $display("[TB] contention of single writes from reset");
      apply_stimulus(0, 0, 1, 28'h0A0, 8'd1, 128'h11);
      apply_stimulus(1, 0, 1, 28'h1A0, 8'd1, 128'h22);
      rst_n = 1'b0;
      tick(2);
      check_output("reset_err_clear", err_rdv, 1'b0);
      rst_n = 1'b1;
      mark = wr_log.size();
      for (int i = 0; i < 20 && wr_log.size() < mark + 4; i++) next_cycle();
      check_output("cont_count", 128'(wr_log.size() - mark), 128'd4);
      check_output("cont_g0", wr_log[mark],     28'h0A0);
      check_output("cont_g1", wr_log[mark + 1], 28'h1A0);
      check_output("cont_g2", wr_log[mark + 2], 28'h0A0);
      check_output("cont_g3", wr_log[mark + 3], 28'h1A0);
      mwr = 2'b00;
      tick(2);

      $display("[TB] write burst lock");
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      mark = wr_log.size();
      apply_stimulus(1, 0, 1, 28'h1B0, 8'd8, 128'h33);
      next_cycle();
      apply_stimulus(0, 0, 1, 28'h0B0, 8'd1, 128'h44);
      beats = 0; m0_hold = 1'b1;
      for (int i = 0; i < 100 && beats < 8; i++) begin
         s_wait = 1'($urandom_range(0, 1));
         #3;
         if (mwait[0] != 1'b1) m0_hold = 1'b0;
         if (mwait[1] == 1'b0) beats++;
         next_cycle();
         mwdata[1] = mwdata[1] + 128'd1;
      end
      mwr[1] = 1'b0;
      s_wait = 1'b0;
      wait_accept(0, 10, ok);
      same = 1'b1;
      for (int i = 0; i < 8; i++) if (wr_log[mark + i] !== 28'h1B0) same = 1'b0;
      check_output("burst_m1_beats", 128'(beats), 128'd8);
      check_output("burst_m0_held", m0_hold, 1'b1);
      check_output("burst_m1_first", same, 1'b1);
      check_output("burst_m0_accept", ok, 1'b1);
      check_output("burst_m0_after", wr_log[mark + 8], 28'h0B0);
      tick(2);

      $display("[TB] read tag FIFO full");
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      mark = rdv_log.size();
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(i % 2, 1, 0, 28'h400 + 28'(16 * i), 8'd2, '0);
         wait_accept(i % 2, 5, ok);
         check_output($sformatf("fifo_acc%0d", i), ok, 1'b1);
      end
      apply_stimulus(0, 1, 0, 28'h440, 8'd2, '0);
      wait_accept(0, 6, ok);
      check_output("fifo_fifth_held", ok, 1'b0);
      s_rdv = 1'b1; s_rdata = 128'hC0;
      #3;
      check_output("fifo_full_wait", mwait[0], 1'b1);
      check_output("fifo_full_s_read", s_read, 1'b0);
      next_cycle();
      s_rdata = 128'hC1;
      next_cycle();
      s_rdv = 1'b0;
      wait_accept(0, 4, ok);
      check_output("fifo_fifth_accept", ok, 1'b1);
      for (int i = 0; i < 8; i++) begin
         s_rdv = 1'b1; s_rdata = 128'hD0 + 128'(i);
         next_cycle();
      end
      s_rdv = 1'b0;
      check_output("fifo_route_count", 128'(rdv_log.size() - mark), 128'd10);
      same = 1'b1;
      for (int i = 0; i < 10; i++) if (rdv_log[mark + i] != exp_route[i]) same = 1'b0;
      check_output("fifo_route_order", same, 1'b1);
      check_output("fifo_no_err", err_rdv, 1'b0);

      $display("[TB] reset during a write burst");
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      apply_stimulus(0, 0, 1, 28'h0C0, 8'd8, 128'h55);
      beats = 0;
      for (int i = 0; i < 20 && beats < 3; i++) begin
         #3;
         if (mwait[0] == 1'b0) beats++;
         next_cycle();
      end
      check_output("rst_burst_beats", 128'(beats), 128'd3);
      rst_n = 1'b0;
      mbc[0] = 8'd1;
      apply_stimulus(1, 0, 1, 28'h1C0, 8'd1, 128'h66);
      next_cycle();
      #3;
      check_output("rst_burst_s_write", s_write, 1'b0);
      check_output("rst_burst_wait", mwait, 2'b11);
      next_cycle();
      rst_n = 1'b1;
      mark2 = wr_log.size();
      for (int i = 0; i < 10 && wr_log.size() == mark2; i++) next_cycle();
      check_output("rst_tie_port0", wr_log[mark2], 28'h0C0);
      mwr = 2'b00;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
